alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one 32-bit MIPS ALU (AND/OR/ADD/SUB/SLT) between two requesters, port A and port B.
- Arbitrates round-robin and sequences one operation at a time through a three-state FSM.
- Holds each result until the owning requester takes it.
- SLT results are zero-extended: the 1-bit compare goes in bit 0, and bits 31:1 are 0.

Parameters:
- WIDTH, 32, operand and result width in bits.
- TAG_W, 4, width of the request tag returned with the result.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- a_req_valid  input  1  requester A has an operation pending.
- a_req_ready  output  1  A's request is accepted this cycle.
- a_op  input  3  A's ALU control code.
- a_src1, a_src2  input  WIDTH  A's operands.
- a_tag  input  TAG_W  A's tag.
- b_req_valid, b_req_ready, b_op, b_src1, b_src2, b_tag: same as the A ports, for requester B.
- resp_valid  output  1  result register holds a valid result.
- resp_ready  input  1  the owning requester consumes the result.
- resp_owner  output  1  0 = result belongs to A, 1 = result belongs to B.
- resp_result  output  WIDTH  ALU result.
- resp_tag  output  TAG_W  tag of the completed request.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values:
  - a_req_ready = 0, b_req_ready = 0, resp_valid = 0.
  - resp_result = 0, resp_tag = 0, resp_owner = 0.
  - last_grant = 1 (B), so A wins the first tie.
- IDLE:
  - Readies are combinational from the valids and last_grant.
  - Only A valid: a_req_ready = 1. Only B valid: b_req_ready = 1.
  - Both valid: grant the port that was not last_grant.
  - At most one ready is high in any cycle. Both readies are 0 outside IDLE.
  - On handshake: latch op/src1/src2/tag and the owner, update last_grant to the owner, go to EXEC.
- EXEC (one cycle):
  - Compute the result into resp_result, copy tag and owner to the outputs.
  - Set resp_valid = 1 and go to RESP.
- ALU ops:
  - 000 AND.
  - 001 OR.
  - 010 ADD, modulo 2^WIDTH, overflow ignored.
  - 110 SUB, modulo 2^WIDTH.
  - 111 SLT: signed src1 < src2, computed overflow-correct (not the sign of the difference); result = {WIDTH-1 zeros, lt}.
  - Any other code: result 0.
- RESP:
  - Hold resp_* stable while resp_ready = 0.
  - When resp_ready = 1: clear resp_valid and return to IDLE on the next edge.
  - A new request is accepted at the earliest in the IDLE cycle after that.
- Latency: handshake at edge N → resp_valid high after edge N+1. Minimum request-to-request spacing is 3 cycles.
- Valid/ready rules:
  - A request is taken only on valid & ready at the clock edge.
  - Operands are sampled only at that edge; later changes have no effect.
  - Deasserting valid before a grant is allowed and no state changes.
- Boundary conditions:
  - resp_ready with resp_valid = 0 is ignored.
  - Reset in EXEC or RESP discards the operation, returns to IDLE, restores all reset values and sets last_grant = 1.
  - Reset has priority over any handshake in the same cycle.

Optional Feature:
- Macro: ALU_SHARE_ZERO_FLAG_EN.
- Defined:
  - Adds output port resp_zero (1 bit), registered in EXEC.
  - resp_zero = 1 when resp_result is all zeros; for SLT this means lt = 0.
  - Reset value 0; held stable in RESP like the other resp_* outputs.
- Undefined:
  - The port is absent.
  - All other behaviour and timing are identical.

Test Plan:
- Reset, then A only, op 010, src1 = 0x00000005, src2 = 0x00000003, tag 3 → a_req_ready = 1 in IDLE; one cycle later resp_valid = 1, resp_result = 0x00000008, resp_owner = 0, resp_tag = 3.
- A and B valid in the same cycle after reset → A granted first; B granted at the next IDLE; a second tie after that grants A again (strict alternation).
- SLT with src1 = 0x80000000, src2 = 0x00000001 → resp_result = 0x00000001. Swapped operands → 0x00000000. src1 = 0x7FFFFFFF, src2 = 0x80000000 → 0x00000000 (overflow-correct).
- SUB 0x00000000 − 0x00000001 → 0xFFFFFFFF. ADD 0xFFFFFFFF + 0x00000001 → 0x00000000 (resp_zero = 1 when ALU_SHARE_ZERO_FLAG_EN is defined).
- Hold resp_ready = 0 for 10 cycles with B valid → resp_* stable, b_req_ready stays 0; on resp_ready = 1, B is accepted in the IDLE cycle that follows.
- Assert reset during EXEC → the next cycle shows IDLE, resp_valid = 0, and A wins the following tie.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: one MIPS ALU shared round-robin by requesters A and B.
// Define ALU_SHARE_ZERO_FLAG_EN to add the registered resp_zero output.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_req_valid,
    output logic             a_req_ready,
    input  logic [2:0]       a_op,
    input  logic [WIDTH-1:0] a_src1,
    input  logic [WIDTH-1:0] a_src2,
    input  logic [TAG_W-1:0] a_tag,
    input  logic             b_req_valid,
    output logic             b_req_ready,
    input  logic [2:0]       b_op,
    input  logic [WIDTH-1:0] b_src1,
    input  logic [WIDTH-1:0] b_src2,
    input  logic [TAG_W-1:0] b_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_owner,
    output logic [WIDTH-1:0] resp_result,
    output logic [TAG_W-1:0] resp_tag
`ifdef ALU_SHARE_ZERO_FLAG_EN
    ,
    output logic             resp_zero
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               last_grant;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   src1_q;
    logic [WIDTH-1:0]   src2_q;
    logic [TAG_W-1:0]   tag_q;
    logic               owner_q;
    logic               grant_a;
    logic               grant_b;
    logic               lt;
    logic [WIDTH-1:0]   alu_out;

    // A wins when alone or when B was served last; B takes what A does not.
    assign grant_a = a_req_valid && (!b_req_valid || last_grant);
    assign grant_b = b_req_valid && !grant_a;

    assign lt = $signed(src1_q) < $signed(src2_q);

    // Shared ALU datapath on the latched request.
    always_comb begin
        alu_out = '0;
        case (op_q)
            3'b000:  alu_out = src1_q & src2_q;
            3'b001:  alu_out = src1_q | src2_q;
            3'b010:  alu_out = src1_q + src2_q;
            3'b110:  alu_out = src1_q - src2_q;
            3'b111:  alu_out = {{(WIDTH-1){1'b0}}, lt};
            default: alu_out = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and request readies; readies only exist in IDLE.
    always_comb begin
        state_next  = state;
        a_req_ready = 1'b0;
        b_req_ready = 1'b0;
        unique case (state)
            IDLE: begin
                if (!reset) begin
                    a_req_ready = grant_a;
                    b_req_ready = grant_b;
                end
                if (a_req_ready || b_req_ready) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture, round-robin history and response register.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant  <= 1'b1;
            op_q        <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            tag_q       <= '0;
            owner_q     <= 1'b0;
            resp_valid  <= 1'b0;
            resp_owner  <= 1'b0;
            resp_result <= '0;
            resp_tag    <= '0;
`ifdef ALU_SHARE_ZERO_FLAG_EN
            resp_zero   <= 1'b0;
`endif
        end else begin
            unique case (1'b1)
                a_req_ready: begin
                    op_q       <= a_op;
                    src1_q     <= a_src1;
                    src2_q     <= a_src2;
                    tag_q      <= a_tag;
                    owner_q    <= 1'b0;
                    last_grant <= 1'b0;
                end
                b_req_ready: begin
                    op_q       <= b_op;
                    src1_q     <= b_src1;
                    src2_q     <= b_src2;
                    tag_q      <= b_tag;
                    owner_q    <= 1'b1;
                    last_grant <= 1'b1;
                end
                default: begin
                end
            endcase
            if (state == EXEC) begin
                resp_valid  <= 1'b1;
                resp_result <= alu_out;
                resp_tag    <= tag_q;
                resp_owner  <= owner_q;
`ifdef ALU_SHARE_ZERO_FLAG_EN
                resp_zero   <= (alu_out == '0);
`endif
            end else if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed scoreboard bench for alu_share_arbiter.
// Checks grants, latency, ALU results, response hold and reset recovery.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req_valid, a_req_ready;
    logic [2:0]  a_op;
    logic [31:0] a_src1, a_src2;
    logic [3:0]  a_tag;
    logic        b_req_valid, b_req_ready;
    logic [2:0]  b_op;
    logic [31:0] b_src1, b_src2;
    logic [3:0]  b_tag;
    logic        resp_valid, resp_ready, resp_owner;
    logic [31:0] resp_result;
    logic [3:0]  resp_tag;
`ifdef ALU_SHARE_ZERO_FLAG_EN
    logic        resp_zero;
`endif

    typedef struct packed {
        logic        owner;
        logic [3:0]  tag;
        logic [31:0] result;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   passes;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    alu_share_arbiter #(.WIDTH(32), .TAG_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .a_req_valid (a_req_valid),
        .a_req_ready (a_req_ready),
        .a_op        (a_op),
        .a_src1      (a_src1),
        .a_src2      (a_src2),
        .a_tag       (a_tag),
        .b_req_valid (b_req_valid),
        .b_req_ready (b_req_ready),
        .b_op        (b_op),
        .b_src1      (b_src1),
        .b_src2      (b_src2),
        .b_tag       (b_tag),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_owner  (resp_owner),
        .resp_result (resp_result),
        .resp_tag    (resp_tag)
`ifdef ALU_SHARE_ZERO_FLAG_EN
        ,
        .resp_zero   (resp_zero)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] op,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        case (op)
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_SLT:  return (x[31] != y[31]) ? {31'b0, x[31]}
                                             : {31'b0, (x < y)};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic drive(input bit p, input logic [2:0] op,
                         input logic [31:0] s1, input logic [31:0] s2,
                         input logic [3:0] tag, input bit push);
        if (!p) begin
            a_req_valid = 1'b1;
            a_op = op;
            a_src1 = s1;
            a_src2 = s2;
            a_tag = tag;
        end else begin
            b_req_valid = 1'b1;
            b_op = op;
            b_src1 = s1;
            b_src2 = s2;
            b_tag = tag;
        end
        if (push) sb.push_back({p, tag, model(op, s1, s2)});
    endtask

    // Wait for the grant of port p, then drop valid and scramble operands.
    task automatic await_grant(input bit p);
        int n = 0;
        bit got = 0;
        while (n < 50) begin
            @(negedge clk);
            if (p ? b_req_ready : a_req_ready) begin
                got = 1;
                break;
            end
            n++;
        end
        chk(p ? "grant_b" : "grant_a", 32'(got), 32'd1);
        chk("grant_wait", 32'(n), 32'd0);
        chk("other_ready", 32'(p ? a_req_ready : b_req_ready), 32'd0);
        @(posedge clk);
        #1;
        if (!p) begin
            a_req_valid = 1'b0;
            a_src1 = ~a_src1;
            a_src2 = ~a_src2;
        end else begin
            b_req_valid = 1'b0;
            b_src1 = ~b_src1;
            b_src2 = ~b_src2;
        end
    endtask

    // Called right after a grant; checks latency, contents and hold.
    task automatic take_resp(input int hold);
        int n = 0;
        exp_t e;
        while (n < 20) begin
            @(negedge clk);
            if (resp_valid) break;
            n++;
        end
        chk("resp_latency", 32'(n), 32'd1);
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("resp_valid", 32'(resp_valid), 32'd1);
            chk("resp_result", resp_result, e.result);
            chk("resp_owner", 32'(resp_owner), 32'(e.owner));
            chk("resp_tag", 32'(resp_tag), 32'(e.tag));
`ifdef ALU_SHARE_ZERO_FLAG_EN
            chk("resp_zero", 32'(resp_zero), 32'(e.result == 32'h0));
`endif
            repeat (hold) begin
                @(negedge clk);
                chk("hold_valid", 32'(resp_valid), 32'd1);
                chk("hold_result", resp_result, e.result);
                chk("hold_tag", 32'(resp_tag), 32'(e.tag));
                chk("hold_owner", 32'(resp_owner), 32'(e.owner));
                chk("hold_b_ready", 32'(b_req_ready), 32'd0);
                chk("hold_a_ready", 32'(a_req_ready), 32'd0);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        passes = 0;
        reset = 1'b1;
        resp_ready = 1'b0;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        a_op = '0; a_src1 = '0; a_src2 = '0; a_tag = '0;
        b_op = '0; b_src1 = '0; b_src2 = '0; b_tag = '0;

        // ADD from A, already valid while reset is held.
        drive(0, OP_ADD, 32'h5, 32'h3, 4'd3, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready", 32'(a_req_ready), 32'd0);
        chk("rst_b_ready", 32'(b_req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_result", resp_result, 32'h0);
        chk("rst_resp_tag", 32'(resp_tag), 32'd0);
        chk("rst_resp_owner", 32'(resp_owner), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        await_grant(0);
        take_resp(0);

        // Fresh reset, then ties alternate A, B, A, B.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, OP_OR, 32'hF0F0_0000, 32'h0FF0_00FF, 4'd1, 1);
        drive(1, OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'd2, 1);
        await_grant(0);
        take_resp(0);
        await_grant(1);
        take_resp(0);
        drive(0, OP_SUB, 32'h0, 32'h1, 4'd4, 1);
        drive(1, OP_ADD, 32'hFFFF_FFFF, 32'h1, 4'd5, 1);
        await_grant(0);
        take_resp(0);
        await_grant(1);
        take_resp(0);

        // SLT corners, including the overflow case, and undefined ops.
        drive(0, OP_SLT, 32'h8000_0000, 32'h1, 4'd8, 1);
        await_grant(0);
        take_resp(0);
        drive(1, OP_SLT, 32'h1, 32'h8000_0000, 4'd9, 1);
        await_grant(1);
        take_resp(0);
        drive(0, OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 4'd10, 1);
        await_grant(0);
        take_resp(0);
        drive(1, OP_SLT, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 4'd11, 1);
        await_grant(1);
        take_resp(0);
        drive(0, 3'b011, 32'h1234, 32'h1, 4'd12, 1);
        await_grant(0);
        take_resp(0);
        drive(1, 3'b101, 32'hFFFF, 32'h1, 4'd13, 1);
        await_grant(1);
        take_resp(0);

        // Response held 10 cycles while B waits; B follows immediately.
        drive(0, OP_ADD, 32'h1234, 32'h1111, 4'd6, 1);
        await_grant(0);
        drive(1, OP_OR, 32'hA000_0000, 32'h0000_000A, 4'd7, 1);
        take_resp(10);
        await_grant(1);
        take_resp(0);

        // Reset while EXEC: op discarded, A wins the next tie.
        drive(0, OP_ADD, 32'h1, 32'h2, 4'd14, 0);
        await_grant(0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rexec_resp_valid", 32'(resp_valid), 32'd0);
        chk("rexec_resp_result", resp_result, 32'h0);
        chk("rexec_resp_tag", 32'(resp_tag), 32'd0);
        @(posedge clk);
        #1;
        drive(0, OP_AND, 32'hFFFF_0000, 32'h00FF_FF00, 4'd15, 1);
        drive(1, OP_SUB, 32'h10, 32'h20, 4'd0, 1);
        await_grant(0);
        take_resp(0);
        await_grant(1);
        take_resp(0);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
